// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one DATA_WIDTH-bit ALU between two requesters (port 0 =
//            core execute stage, port 1 = auxiliary/debug path). Grants one
//            request at a time (round robin when both ask), registers the
//            operands onto the ALU inputs, waits the op's execution time,
//            captures result and flags, and returns them through a
//            valid/ready handshake tagged with the winning port.
// Revision : 1.0 - initial release
//
// Ports:
//   clock, reset              rising-edge clock, async active-low reset
//   req0/1, op0/1, a0/1, b0/1, shamt0/1
//                             request + operands, held until ack
//   ack0/1                    one-cycle accept pulse (combinational, IDLE)
//   aluSelection, dataA, dataB2, shamt
//                             registered ALU inputs
//   aluOut, zero, negative    ALU result and flags
//   resValid/resReady         result handshake
//   resData, resTag, resZero, resNegative, resDivZero
//                             captured result, issuing port and flags
//   busy                      any state other than IDLE
//
// Configuration macro: ALU_ARB_DIVZERO_EN
//   defined   : divide/modulo by zero finishes after one EXEC cycle with a
//               substituted result (div: all ones, mod: dataA), resDivZero=1
//   undefined : divide/modulo by zero is timed and returned like any other
//               mul/div op; resDivZero is tied low
// ============================================================================
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [3:0]            op0,
  input  logic [3:0]            op1,
  input  logic [DATA_WIDTH-1:0] a0,
  input  logic [DATA_WIDTH-1:0] a1,
  input  logic [DATA_WIDTH-1:0] b0,
  input  logic [DATA_WIDTH-1:0] b1,
  input  logic [4:0]            shamt0,
  input  logic [4:0]            shamt1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [3:0]            aluSelection,
  output logic [DATA_WIDTH-1:0] dataA,
  output logic [DATA_WIDTH-1:0] dataB2,
  output logic [4:0]            shamt,
  input  logic [DATA_WIDTH-1:0] aluOut,
  input  logic                  zero,
  input  logic                  negative,
  output logic                  resValid,
  input  logic                  resReady,
  output logic [DATA_WIDTH-1:0] resData,
  output logic                  resTag,
  output logic                  resZero,
  output logic                  resNegative,
  output logic                  resDivZero,
  output logic                  busy
);

  localparam logic [3:0] C_OP_MUL   = 4'b1100;
  localparam logic [3:0] C_OP_DIV   = 4'b1101;
  localparam logic [3:0] C_OP_MOD   = 4'b1110;
  localparam logic [3:0] C_OP_UNDEF = 4'b1111;
  // Counter value loaded on accept so that EXEC lasts MULDIV_CYCLES cycles.
  localparam logic [3:0] C_MD_LOAD  = 4'(MULDIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_grant;
  logic [3:0]            r_cnt;

  logic [3:0]            r_alu_sel;
  logic [DATA_WIDTH-1:0] r_data_a;
  logic [DATA_WIDTH-1:0] r_data_b;
  logic [4:0]            r_shamt;
  logic                  r_res_valid;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  r_res_tag;
  logic                  r_res_zero;
  logic                  r_res_neg;

  logic                  w_grant;
  logic                  w_grant_port;
  logic [3:0]            w_sel_op;
  logic [DATA_WIDTH-1:0] w_sel_a;
  logic [DATA_WIDTH-1:0] w_sel_b;
  logic [4:0]            w_sel_shamt;
  logic                  w_sel_muldiv;
  logic                  w_req_divzero;
  logic [3:0]            w_cnt_load;

  logic [DATA_WIDTH-1:0] w_cap_data;
  logic                  w_cap_zero;
  logic                  w_cap_neg;

  // --------------------------------------------------------------------------
  // Next state, arbitration and accept pulses
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_grant_port = 1'b0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 && req1) begin
          // Round robin: the port that did not win last time goes first.
          w_grant      = 1'b1;
          w_grant_port = ~r_last_grant;
        end else if (req0 || req1) begin
          w_grant      = 1'b1;
          w_grant_port = req1;
        end
        ack0 = w_grant && !w_grant_port;
        ack1 = w_grant && w_grant_port;
        if (w_grant) w_next_state = S_EXEC;
      end
      S_EXEC: begin
        if (r_cnt == 4'd0) w_next_state = S_DONE;
      end
      S_DONE: begin
        if (resReady) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operands of the winning port
  assign w_sel_op     = w_grant_port ? op1    : op0;
  assign w_sel_a      = w_grant_port ? a1     : a0;
  assign w_sel_b      = w_grant_port ? b1     : b0;
  assign w_sel_shamt  = w_grant_port ? shamt1 : shamt0;
  assign w_sel_muldiv = (w_sel_op == C_OP_MUL) || (w_sel_op == C_OP_DIV) ||
                        (w_sel_op == C_OP_MOD);

`ifdef ALU_ARB_DIVZERO_EN
  logic w_exec_divzero;
  logic r_res_divzero;

  assign w_req_divzero  = ((w_sel_op == C_OP_DIV) || (w_sel_op == C_OP_MOD)) &&
                          (w_sel_b == '0);
  assign w_exec_divzero = ((r_alu_sel == C_OP_DIV) || (r_alu_sel == C_OP_MOD)) &&
                          (r_data_b == '0);
  assign resDivZero     = r_res_divzero;
`else
  assign w_req_divzero  = 1'b0;
  assign resDivZero     = 1'b0;
`endif

  // Div/mod by zero skips the multi-cycle wait when the feature is enabled.
  assign w_cnt_load = (w_sel_muldiv && !w_req_divzero) ? C_MD_LOAD : 4'd0;

  // --------------------------------------------------------------------------
  // Result substitution at capture time
  // --------------------------------------------------------------------------
  always_comb begin
    w_cap_data = aluOut;
    w_cap_zero = zero;
    w_cap_neg  = negative;
    // The ALU leaves op 1111 undefined, so its output is replaced by zero.
    if (r_alu_sel == C_OP_UNDEF) begin
      w_cap_data = '0;
      w_cap_zero = 1'b1;
      w_cap_neg  = 1'b0;
    end
`ifdef ALU_ARB_DIVZERO_EN
    else if (w_exec_divzero) begin
      w_cap_data = (r_alu_sel == C_OP_DIV) ? {DATA_WIDTH{1'b1}} : r_data_a;
      w_cap_zero = 1'b0;
      w_cap_neg  = w_cap_data[DATA_WIDTH-1];
    end
`endif
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= 4'd0;
      r_alu_sel    <= 4'd0;
      r_data_a     <= '0;
      r_data_b     <= '0;
      r_shamt      <= 5'd0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_tag    <= 1'b0;
      r_res_zero   <= 1'b0;
      r_res_neg    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_alu_sel    <= w_sel_op;
            r_data_a     <= w_sel_a;
            r_data_b     <= w_sel_b;
            r_shamt      <= w_sel_shamt;
            r_res_tag    <= w_grant_port;
            r_last_grant <= w_grant_port;
            r_cnt        <= w_cnt_load;
          end else begin
            r_alu_sel <= 4'd0;
          end
        end
        S_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_res_data  <= w_cap_data;
            r_res_zero  <= w_cap_zero;
            r_res_neg   <= w_cap_neg;
            r_res_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (resReady) r_res_valid <= 1'b0;
        end
        default: r_res_valid <= 1'b0;
      endcase
    end
  end

`ifdef ALU_ARB_DIVZERO_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_res_divzero <= 1'b0;
    end else if ((r_state == S_EXEC) && (r_cnt == 4'd0)) begin
      r_res_divzero <= w_exec_divzero;
    end
  end
`endif

  assign aluSelection = r_alu_sel;
  assign dataA        = r_data_a;
  assign dataB2       = r_data_b;
  assign shamt        = r_shamt;
  assign resValid     = r_res_valid;
  assign resData      = r_res_data;
  assign resTag       = r_res_tag;
  assign resZero      = r_res_zero;
  assign resNegative  = r_res_neg;
  assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. Contains a behavioural ALU
//            driven by the arbiter's registered ALU inputs and a transaction
//            level reference (round-robin owner, latency and result rules).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int MD = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [3:0]    op0, op1;
  logic [DW-1:0] a0, a1, b0, b1;
  logic [4:0]    shamt0, shamt1;
  logic          ack0, ack1;
  logic [3:0]    aluSelection;
  logic [DW-1:0] dataA, dataB2;
  logic [4:0]    shamt;
  logic [DW-1:0] aluOut;
  logic          zero, negative;
  logic          resValid, resReady;
  logic [DW-1:0] resData;
  logic          resTag, resZero, resNegative, resDivZero, busy;

  int checks   = 0;
  int failures = 0;
  bit last_grant;

  alu_arbiter #(.DATA_WIDTH(DW), .MULDIV_CYCLES(MD)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .shamt0(shamt0), .shamt1(shamt1),
    .ack0(ack0), .ack1(ack1),
    .aluSelection(aluSelection), .dataA(dataA), .dataB2(dataB2), .shamt(shamt),
    .aluOut(aluOut), .zero(zero), .negative(negative),
    .resValid(resValid), .resReady(resReady), .resData(resData),
    .resTag(resTag), .resZero(resZero), .resNegative(resNegative),
    .resDivZero(resDivZero), .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural ALU; op 1111 returns junk on purpose.
  function automatic logic [DW-1:0] alu_ref(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [4:0] sh);
    case (op)
      4'h0: return a & b;
      4'h1: return a + b;
      4'h2: return a - b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~(a | b);
      4'h6: return {31'd0, $signed(a) < $signed(b)};
      4'h7: return {31'd0, a < b};
      4'h8: return a >> sh;
      4'h9: return a << sh;
      4'hA: return $signed(a) >>> sh;
      4'hB: return b;
      4'hC: return a * b;
      4'hD: return (b == 0) ? 32'hDEAD_BEEF : a / b;
      4'hE: return (b == 0) ? 32'hCAFE_0000 : a % b;
      default: return 32'h9234_5678;
    endcase
  endfunction

  always_comb begin
    aluOut   = alu_ref(aluSelection, dataA, dataB2, shamt);
    zero     = (aluOut == '0);
    negative = aluOut[DW-1];
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; resReady = 1'b0;
    last_grant = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_valid", resValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alusel", aluSelection, 0);
    chk("rst_data", dataA | dataB2 | resData, 0);
    chk("rst_tag_flags", {resTag, resZero, resNegative, resDivZero, ack0, ack1}, 0);
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  // Serves one grant from the currently applied requests. Called just after
  // a rising edge; returns just after the handshake edge.
  task automatic serve(input int stall);
    bit got, exp_p, seen, busy_ok, noack_ok, in_ok, hold_ok;
    int waited, cyc, elat;
    logic [3:0] op; logic [DW-1:0] a, b, ed; logic [4:0] sh;
    bit ez, en, edz;
    exp_p = (req0 && req1) ? ~last_grant : req1;
    op = exp_p ? op1 : op0; a = exp_p ? a1 : a0;
    b  = exp_p ? b1  : b0;  sh = exp_p ? shamt1 : shamt0;
    if (op == 4'hF) begin
      ed = '0; ez = 1; en = 0; edz = 0;
    end
`ifdef ALU_ARB_DIVZERO_EN
    else if ((op == 4'hD || op == 4'hE) && b == 0) begin
      ed = (op == 4'hD) ? '1 : a; ez = 0; en = ed[DW-1]; edz = 1;
    end
`endif
    else begin
      ed = alu_ref(op, a, b, sh); ez = (ed == 0); en = ed[DW-1]; edz = 0;
    end
    elat = (op >= 4'hC && op <= 4'hE) ? MD + 1 : 2;
`ifdef ALU_ARB_DIVZERO_EN
    if ((op == 4'hD || op == 4'hE) && b == 0) elat = 2;
`endif
    got = 0; waited = 0;
    @(negedge clock);
    while (!got && waited < 30) begin
      if (ack0 || ack1) got = 1;
      else begin waited++; @(negedge clock); end
    end
    chk("ack_seen", got, 1);
    if (!got) return;
    chk("grant_port", {ack1, ack0}, exp_p ? 2'b10 : 2'b01);
    last_grant = exp_p;
    @(posedge clock); #1;
    if (exp_p) req1 = 1'b0; else req0 = 1'b0;
    cyc = 0; seen = 0; busy_ok = 1; noack_ok = 1; in_ok = 1;
    while (!seen && cyc < 40) begin
      @(negedge clock); cyc++;
      if (resValid) seen = 1;
      else begin
        if (busy !== 1'b1) busy_ok = 0;
        if (ack0 || ack1) noack_ok = 0;
        if (aluSelection !== op || dataA !== a || dataB2 !== b || shamt !== sh) in_ok = 0;
      end
    end
    chk("latency", cyc, elat);
    chk("exec_busy", busy_ok, 1);
    chk("exec_noack", noack_ok, 1);
    chk("alu_inputs", in_ok, 1);
    chk("resData", resData, ed);
    chk("resTag", resTag, exp_p);
    chk("resZero", resZero, ez);
    chk("resNegative", resNegative, en);
    chk("resDivZero", resDivZero, edz);
    hold_ok = 1;
    repeat (stall) begin
      @(posedge clock); @(negedge clock);
      if (resValid !== 1 || resData !== ed || resTag !== exp_p || resZero !== ez ||
          resNegative !== en || resDivZero !== edz || busy !== 1 || ack0 || ack1)
        hold_ok = 0;
    end
    chk("stall_hold", hold_ok, 1);
    resReady = 1'b1;
    @(posedge clock); #1;
    resReady = 1'b0;
    chk("valid_drop", resValid, 0);
  endtask

  initial begin
    bit nv_ok;
    int mode;
    reset = 1'b0; req0 = 0; req1 = 0; resReady = 0;
    op0 = 0; op1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0; shamt0 = 0; shamt1 = 0;
    do_reset();

    // Simultaneous subtracts right after reset: port 0 first.
    req0 = 1; op0 = 4'h2; a0 = 3; b0 = 3; shamt0 = 0;
    req1 = 1; op1 = 4'h2; a1 = 1; b1 = 2; shamt1 = 0;
    serve(0);
    serve(0);

    // Single add on port 0.
    req0 = 1; op0 = 4'h1; a0 = 5; b0 = 7;
    serve(0);

    // Divide on port 1 with a three-cycle consumer stall.
    req1 = 1; op1 = 4'hD; a1 = 100; b1 = 7;
    serve(3);

    // Divide and modulo by zero.
    req0 = 1; op0 = 4'hD; a0 = 9; b0 = 0;
    serve(1);
    req0 = 1; op0 = 4'hE; a0 = 9; b0 = 0;
    serve(0);

    // Shift to the sign bit, then the undefined op.
    req1 = 1; op1 = 4'h9; a1 = 1; b1 = 0; shamt1 = 31;
    serve(0);
    req0 = 1; op0 = 4'hF; a0 = 32'h1234; b0 = 32'h55;
    serve(0);

    // Reset in the middle of a multiply.
    req0 = 1; op0 = 4'hC; a0 = 6; b0 = 7;
    @(negedge clock);
    chk("mid_ack", ack0, 1);
    @(posedge clock); #1; req0 = 0;
    @(negedge clock); @(negedge clock);
    reset = 1'b0; last_grant = 1'b1;
    #1;
    chk("mid_rst_state", {busy, resValid}, 0);
    chk("mid_rst_alu", {aluSelection, dataA[7:0], dataB2[7:0]}, 0);
    @(negedge clock); reset = 1'b1;
    nv_ok = 1;
    repeat (10) begin
      @(negedge clock);
      if (resValid !== 0 || busy !== 0) nv_ok = 0;
    end
    chk("mid_rst_no_result", nv_ok, 1);
    @(posedge clock); #1;
    req0 = 1; op0 = 4'hC; a0 = 6; b0 = 7;
    serve(0);

    // Randomised traffic.
    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 2);
      op0 = 4'($urandom_range(0, 15)); a0 = $urandom; shamt0 = 5'($urandom_range(0, 31));
      b0 = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      op1 = 4'($urandom_range(0, 15)); a1 = $urandom; shamt1 = 5'($urandom_range(0, 31));
      b1 = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      req0 = (mode != 1); req1 = (mode != 0);
      serve($urandom_range(0, 3));
      if (mode == 2) serve($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
